// File: rtl/pulse_meas.sv
// Pulse high-time and period measurement from edge-detector pulses, one result per period via valid/ready.
// Optional PULSE_MEAS_DROP_CNT_EN adds an 8-bit saturating count of discarded results (drop_cnt).
module pulse_meas #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise_edge,
  input  logic             fall_edge,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sat,
  output logic             dropped
`ifdef PULSE_MEAS_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_latch;
  logic             sat_flag;
  logic             capture_fall;
  logic             complete;
  logic             load_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A rise always wins over a simultaneous fall, so every branch tests rise first.
  always_comb begin
    state_nxt    = state;
    capture_fall = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: if (rise_edge) state_nxt = HIGH;
      HIGH: begin
        if (rise_edge) begin
          state_nxt = HIGH;
        end else if (fall_edge) begin
          capture_fall = 1'b1;
          state_nxt    = LOW;
        end
      end
      LOW: begin
        if (rise_edge) begin
          complete  = 1'b1;
          state_nxt = HIGH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky saturation flag marks a count that got stuck at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (rise_edge) begin
      cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
      sat_flag <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      sat_flag <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               high_latch <= '0;
    else if (capture_fall) high_latch <= cnt;
  end

  assign load_ok = !valid_out || ready_in;

  // Holding register: a completed result loads when free or being consumed this cycle, else it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      sat        <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (complete && load_ok) begin
        valid_out  <= 1'b1;
        high_cnt   <= high_latch;
        period_cnt <= cnt;
        sat        <= sat_flag || (cnt == CNT_MAX);
      end else if (complete) begin
        dropped <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef PULSE_MEAS_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             drop_cnt <= 8'd0;
    else if (dropped && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  // No drop counter in this build; the dropped pulse alone reports discards.
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Scoreboard bench for pulse_meas: directed edge patterns push expected results, monitors pop on each handshake.
module tb_pulse_meas;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] per;
    logic        sat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rise_edge, fall_edge, ready_in;
  logic        valid_out, sat, dropped;
  logic [15:0] high_cnt, period_cnt;
  logic        rise_b, fall_b, ready_b;
  logic        valid_b, sat_b, dropped_b;
  logic [3:0]  high_b, period_b;
`ifdef PULSE_MEAS_DROP_CNT_EN
  logic [7:0]  drop_cnt, drop_cnt_b;
`endif

  res_t qa[$];
  res_t qb[$];
  res_t ea, eb;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic        pv, pr, ps;
  logic [15:0] ph, pp;

  always #5 clk = ~clk;

  pulse_meas #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .rise_edge(rise_edge), .fall_edge(fall_edge),
    .ready_in(ready_in), .valid_out(valid_out), .high_cnt(high_cnt),
    .period_cnt(period_cnt), .sat(sat), .dropped(dropped)
`ifdef PULSE_MEAS_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  pulse_meas #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rise_edge(rise_b), .fall_edge(fall_b),
    .ready_in(ready_b), .valid_out(valid_b), .high_cnt(high_b),
    .period_cnt(period_b), .sat(sat_b), .dropped(dropped_b)
`ifdef PULSE_MEAS_DROP_CNT_EN
    , .drop_cnt(drop_cnt_b)
`endif
  );

  function automatic res_t mk(input int hi, input int per, input logic s);
    res_t r;
    r.hi  = hi[15:0];
    r.per = per[15:0];
    r.sat = s;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // One cycle of stimulus on DUT A; returns #1 into the following cycle.
  task automatic applyStimulus(input logic r, input logic f, input logic rdy, input logic rs);
    rise_edge = r;
    fall_edge = f;
    ready_in  = rdy;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    rise_edge = 1'b0;
    fall_edge = 1'b0;
    ready_in  = 1'b0;
    rise_b    = 1'b0;
    fall_b    = 1'b0;
    ready_b   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_high", high_cnt, 0);
    checkOutput("rst_period", period_cnt, 0);
    checkOutput("rst_sat", sat, 0);
    checkOutput("rst_dropped", dropped, 0);
    checkOutput("rst_valid_b", valid_b, 0);
    rst = 1'b0;
  endtask

  // Monitor: compares on every completed transfer and checks hold-stability under back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        checkOutput("a_hold_valid", valid_out, 1);
        checkOutput("a_hold_fields", {high_cnt, period_cnt}, {ph, pp});
        checkOutput("a_hold_sat", sat, ps);
      end
      if (valid_out && ready_in) begin
        checkOutput("a_result_expected", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          checkOutput("a_high_cnt", high_cnt, ea.hi);
          checkOutput("a_period_cnt", period_cnt, ea.per);
          checkOutput("a_sat", sat, ea.sat);
        end
      end
      if (valid_b && ready_b) begin
        checkOutput("b_result_expected", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          checkOutput("b_high_cnt", high_b, eb.hi);
          checkOutput("b_period_cnt", period_b, eb.per);
          checkOutput("b_sat", sat_b, eb.sat);
        end
      end
      pv = valid_out;
      pr = ready_in;
      ph = high_cnt;
      pp = period_cnt;
      ps = sat;
    end
  end

  initial begin
    pv = 1'b0;
    pr = 1'b0;

    $display("[TB] basic");
    resetDut();
    for (int c = 0; c <= 12; c++) begin
      if (c == 10) qa.push_back(mk(3, 8, 1'b0));
      applyStimulus(c == 2 || c == 10, c == 5, 1'b1, 1'b0);
      if (c == 10) begin
        checkOutput("basic_valid11", valid_out, 1);
        checkOutput("basic_high11", high_cnt, 3);
        checkOutput("basic_period11", period_cnt, 8);
        checkOutput("basic_sat11", sat, 0);
      end
      if (c == 11) checkOutput("basic_valid12", valid_out, 0);
    end

    $display("[TB] back-pressure");
    resetDut();
    for (int c = 0; c <= 21; c++) begin
      if (c == 10) qa.push_back(mk(3, 8, 1'b0));
      applyStimulus(c == 2 || c == 10 || c == 18, c == 5 || c == 13, c >= 20, 1'b0);
      if (c == 17) checkOutput("bp_dropped18", dropped, 0);
      if (c == 18) begin
        checkOutput("bp_dropped19", dropped, 1);
        checkOutput("bp_valid19", valid_out, 1);
        checkOutput("bp_high19", high_cnt, 3);
      end
      if (c == 19) begin
        checkOutput("bp_dropped20", dropped, 0);
        checkOutput("bp_valid20", valid_out, 1);
      end
      if (c == 20) checkOutput("bp_valid21", valid_out, 0);
    end
`ifdef PULSE_MEAS_DROP_CNT_EN
    checkOutput("bp_drop_cnt", drop_cnt, 1);
`endif

    $display("[TB] missing fall");
    resetDut();
    for (int c = 0; c <= 15; c++) begin
      if (c == 14) qa.push_back(mk(3, 8, 1'b0));
      applyStimulus(c == 2 || c == 6 || c == 14, c == 9, 1'b1, 1'b0);
      if (c == 6) checkOutput("mf_valid7", valid_out, 0);
      if (c == 14) begin
        checkOutput("mf_valid15", valid_out, 1);
        checkOutput("mf_period15", period_cnt, 8);
      end
    end

    $display("[TB] reset mid-operation");
    resetDut();
    for (int c = 0; c <= 17; c++) begin
      if (c == 16) qa.push_back(mk(2, 6, 1'b0));
      applyStimulus(c == 2 || c == 10 || c == 16, c == 4 || c == 12, 1'b1, c == 6 || c == 7);
      if (c == 6) checkOutput("rm_valid_in_rst", valid_out, 0);
      if (c == 15) checkOutput("rm_valid16", valid_out, 0);
      if (c == 16) begin
        checkOutput("rm_valid17", valid_out, 1);
        checkOutput("rm_high17", high_cnt, 2);
        checkOutput("rm_period17", period_cnt, 6);
      end
    end

    $display("[TB] simultaneous rise and fall");
    resetDut();
    for (int c = 0; c <= 12; c++) begin
      if (c == 11) qa.push_back(mk(3, 6, 1'b0));
      applyStimulus(c == 2 || c == 5 || c == 11, c == 5 || c == 8, 1'b1, 1'b0);
      if (c == 11) begin
        checkOutput("sim_high12", high_cnt, 3);
        checkOutput("sim_period12", period_cnt, 6);
      end
    end

    $display("[TB] minimum values and consume-with-load");
    resetDut();
    for (int c = 0; c <= 9; c++) begin
      if (c == 3) qa.push_back(mk(1, 2, 1'b0));
      if (c == 7) qa.push_back(mk(2, 4, 1'b0));
      applyStimulus(c == 1 || c == 3 || c == 7, c == 2 || c == 5, c >= 7, 1'b0);
      if (c == 3) begin
        checkOutput("min_high4", high_cnt, 1);
        checkOutput("min_period4", period_cnt, 2);
      end
      if (c == 7) begin
        checkOutput("cl_valid8", valid_out, 1);
        checkOutput("cl_dropped8", dropped, 0);
        checkOutput("cl_high8", high_cnt, 2);
        checkOutput("cl_period8", period_cnt, 4);
      end
      if (c == 8) checkOutput("cl_valid9", valid_out, 0);
    end

    $display("[TB] saturation on 4-bit instance");
    resetDut();
    for (int c = 0; c <= 31; c++) begin
      if (c == 30) qb.push_back(mk(15, 15, 1'b1));
      rise_b  = (c == 0 || c == 30);
      fall_b  = (c == 20);
      ready_b = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (c == 30) begin
        checkOutput("sat_valid31", valid_b, 1);
        checkOutput("sat_high31", high_b, 15);
        checkOutput("sat_period31", period_b, 15);
        checkOutput("sat_flag31", sat_b, 1);
      end
    end
    rise_b = 1'b0;
    fall_b = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    checkOutput("qa_drained", qa.size(), 0);
    checkOutput("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
